mcu_sequencer: RTL and testbench

- Generates the 3-bit machine state that drives the microcontroller control unit. It sequences program load, then the FETCH/DECODE/EXECUTE loop, and supports halt, single-step and restart.
- Sits between the top-level microcontroller wrapper, the external program loader and the control unit.
- Owns the program-load address counter and a retired-instruction counter.

---
 rtl/mcu_pkg.sv | 20 ++
 rtl/mcu_load_counter.sv | 46 ++++
 rtl/mcu_sequencer.sv | 129 ++++++++++++
 tb/tb_mcu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the microcontroller sequencer and control unit:
// machine-state encoding, instruction width and default halt word.
package mcu_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned STATE_W = 3;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 12'h0FF;

  // Encodings 6 and 7 are unused; the control unit decodes them as idle.
  typedef enum logic [STATE_W-1:0] {
    LOAD    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    STOP    = 3'd4,
    PAUSE   = 3'd5
  } state_t;

endpackage

// File: rtl/mcu_load_counter.sv
// Program-load handshake: start-gated ready, write address counter and
// terminal detection (last word or top of program memory).
module mcu_load_counter #(
  parameter int unsigned PMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              start,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_addr,
  output logic              done_c
);

  logic loading;
  logic hs_c;
  logic term_c;

  assign hs_c   = active & load_valid & load_ready;
  assign term_c = (load_addr == ADDR_W'(PMEM_DEPTH - 1));
  assign done_c = hs_c & (load_last | term_c);

  // Ready follows start by one cycle; completion clears everything for the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loading    <= 1'b0;
      load_ready <= 1'b0;
      load_addr  <= '0;
    end else if (!active || done_c) begin
      loading    <= 1'b0;
      load_ready <= 1'b0;
      load_addr  <= '0;
    end else if (!loading) begin
      if (start) begin
        loading    <= 1'b1;
        load_ready <= 1'b1;
      end
    end else if (hs_c) begin
      load_addr <= load_addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Machine-state sequencer: program load, FETCH/DECODE/EXECUTE loop, halt,
// single-step and restart. Optional breakpoint support under SEQ_BREAKPOINT_EN.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned          PMEM_DEPTH = 256,
  parameter int unsigned          ADDR_W     = 8,
  parameter logic [INSTR_W-1:0]   HALT_WORD  = HALT_WORD_DEFAULT,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               load_ready,
  output logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] ir,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               step_mode,
  input  logic               step_req,
  input  logic               restart,
  output logic [STATE_W-1:0] state,
`ifdef SEQ_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
`endif
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  state_t state_q;
  state_t state_d;
  logic   load_done_c;
  logic   bp_hit_c;
  logic   bp_trig_c;

  mcu_load_counter #(
    .PMEM_DEPTH (PMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_load_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state_q == LOAD),
    .start      (start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .done_c     (load_done_c)
  );

`ifdef SEQ_BREAKPOINT_EN
  logic bp_armed;

  assign bp_hit_c = bp_en & bp_armed & (pc == bp_addr);

  // One-shot: cleared when the breakpoint fires, re-armed by the next EXECUTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_armed <= 1'b1;
    end else if (state_q == EXECUTE) begin
      bp_armed <= ~bp_trig_c;
    end
  end
`else
  logic pc_unused;

  assign pc_unused = ^pc;
  assign bp_hit_c  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bp_trig_c = 1'b0;
    case (state_q)
      LOAD:    if (load_done_c) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        if (ir == HALT_WORD) begin
          state_d = STOP;
        end else if (step_mode) begin
          state_d = PAUSE;
        end else if (bp_hit_c) begin
          state_d   = PAUSE;
          bp_trig_c = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      STOP:    if (restart) state_d = LOAD;
      PAUSE: begin
        if (restart) begin
          state_d = LOAD;
        end else if (step_req) begin
          state_d = FETCH;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign state = STATE_W'(state_q);

  // Retired-instruction count: saturating, cleared when a new program finishes loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      halted <= (state_d == STOP);
      if (load_done_c) begin
        instr_count <= '0;
      end else if (state_q == EXECUTE && instr_count != '1) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_mcu_sequencer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 8;
  localparam int unsigned CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;
  localparam logic [11:0] HALT   = 12'h0FF;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          load_valid;
  logic          load_last;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [11:0]   ir;
  logic [AW-1:0] pc;
  logic          step_mode;
  logic          step_req;
  logic          restart;
  logic [2:0]    state;
  logic          halted;
  logic [CW-1:0] instr_count;
`ifdef SEQ_BREAKPOINT_EN
  logic          bp_en;
  logic [AW-1:0] bp_addr;
`endif

  mcu_sequencer #(
    .PMEM_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .HALT_WORD  (HALT),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .ir          (ir),
    .pc          (pc),
    .step_mode   (step_mode),
    .step_req    (step_req),
    .restart     (restart),
    .state       (state),
`ifdef SEQ_BREAKPOINT_EN
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
`endif
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model, in specification terms.
  int m_state;
  int m_addr;
  int m_count;
  bit m_loading;
  bit m_armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_addr    = 0;
    m_count   = 0;
    m_loading = 1'b0;
    m_armed   = 1'b1;
  endtask

  task automatic model_tick();
    bit bp_fire;
    bp_fire = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_state)
        0: begin
          if (!m_loading) begin
            if (start) m_loading = 1'b1;
          end else if (load_valid) begin
            if (load_last || m_addr == DEPTH - 1) begin
              m_state = 1; m_loading = 1'b0; m_addr = 0; m_count = 0;
            end else begin
              m_addr = m_addr + 1;
            end
          end
        end
        1: m_state = 2;
        2: m_state = 3;
        3: begin
          if (m_count < CMAX) m_count = m_count + 1;
`ifdef SEQ_BREAKPOINT_EN
          bp_fire = bp_en && (pc == bp_addr) && m_armed;
`endif
          if (ir == HALT) m_state = 4;
          else if (step_mode) m_state = 5;
          else if (bp_fire) m_state = 5;
          else m_state = 1;
          m_armed = !(bp_fire && ir != HALT && !step_mode);
        end
        4: if (restart) m_state = 0;
        5: begin
          if (restart) m_state = 0;
          else if (step_req) m_state = 1;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  // Every cycle: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(state), 32'(m_state));
      check("load_ready", 32'(load_ready), 32'(m_loading));
      check("load_addr", 32'(load_addr), 32'(m_addr));
      check("halted", 32'(halted), 32'(m_state == 4));
      check("instr_count", 32'(instr_count), 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_load(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      load_last = (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_state(input string name, input int target, input int bound);
    for (int i = 0; i < bound && state != 3'(target); i++) tick();
    check(name, 32'(state), 32'(target));
  endtask

  int exp_seq[10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 4};
  int hs;

  initial begin
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    ir = 12'h000; pc = '0; step_mode = 1'b0; step_req = 1'b0; restart = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = AW'(5);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_state", 32'(state), 0);
    check("rst_ready", 32'(load_ready), 0);
    check("rst_addr", 32'(load_addr), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", 32'(instr_count), 0);
    rst_n = 1'b1;

    // Three-word load: addresses 0,1,2 on the handshakes, then FETCH.
    tick();
    check("ready_before_start", 32'(load_ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", 32'(load_ready), 1);
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_last = (i == 2);
      check("hs_addr", 32'(load_addr), 32'(i));
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("exit_state", 32'(state), 1);
    check("exit_addr", 32'(load_addr), 0);
    check("exit_ready", 32'(load_ready), 0);

    // Two ordinary instructions, then the halt word.
    ir = 12'h100;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) ir = HALT;
      check("run_seq", 32'(state), 32'(exp_seq[i]));
      tick();
    end
    check("stop_halted", 32'(halted), 1);
    check("stop_count", 32'(instr_count), 3);

    // Restart from STOP with step_req held: back to LOAD, not loading.
    restart = 1'b1; step_req = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_state", 32'(state), 0);
    tick(); tick();
    check("restart_ready", 32'(load_ready), 0);
    check("restart_halted", 32'(halted), 0);
    step_req = 1'b0;

    // Single-step mode.
    ir = 12'h100;
    do_load(2);
    step_mode = 1'b1;
    wait_state("pause_reached", 5, 10);
    check("pause_count", 32'(instr_count), 1);
    tick(); tick();
    step_mode = 1'b0;
    tick();
    check("pause_hold", 32'(state), 5);
    step_mode = 1'b1; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_f", 32'(state), 1);
    tick();
    check("step_d", 32'(state), 2);
    tick();
    check("step_e", 32'(state), 3);
    tick();
    check("step_pause", 32'(state), 5);
    check("step_count", 32'(instr_count), 2);
    restart = 1'b1; step_req = 1'b1;
    tick();
    restart = 1'b0; step_req = 1'b0; step_mode = 1'b0;
    check("pause_restart", 32'(state), 0);

    // No load_last: exactly DEPTH handshakes before FETCH.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 40 && state == 3'd0; i++) begin
      if (load_valid && load_ready) hs++;
      tick();
    end
    load_valid = 1'b0;
    check("depth_handshakes", 32'(hs), 32'(DEPTH));
    check("depth_state", 32'(state), 1);
    check("depth_ready", 32'(load_ready), 0);

    // Asynchronous reset in the middle of DECODE.
    tick();
    check("pre_rst_decode", 32'(state), 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", 32'(state), 0);
    tick();
    rst_n = 1'b1;

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint at pc 5 fires once; the step executes it without re-pausing.
    bp_en = 1'b1; bp_addr = AW'(5); pc = AW'(5); ir = 12'h100;
    do_load(1);
    wait_state("bp_pause", 5, 10);
    check("bp_count", 32'(instr_count), 1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(); tick(); tick();
    check("bp_no_retrigger", 32'(state), 1);
    pc = AW'(6); bp_en = 1'b0;
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom % 4) == 0;
      load_valid = ($urandom % 2) == 0;
      load_last  = ($urandom % 6) == 0;
      ir         = (($urandom % 12) == 0) ? HALT : 12'($urandom);
      step_mode  = ($urandom % 6) == 0;
      step_req   = ($urandom % 5) == 0;
      restart    = ($urandom % 30) == 0;
      pc         = AW'($urandom % 8);
`ifdef SEQ_BREAKPOINT_EN
      bp_en      = ($urandom % 2) == 0;
`endif
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
